// File: rtl/ctrl_step_sequencer.sv
// ctrl_step_sequencer: Moore control-step FSM for the multi-cycle processor.
// Runs the shared fetch (T0-T2), decodes the IR opcode in T3 and drives the
// per-step datapath strobes until the instruction returns to T0.
module ctrl_step_sequencer #(
    parameter int             IR_W          = 32,
    parameter int             OPW           = 5,
    parameter int             MEM_HANDSHAKE = 1,
    parameter logic [OPW-1:0] OP_LD         = 5'b00000,
    parameter logic [OPW-1:0] OP_ST         = 5'b00010,
    parameter logic [OPW-1:0] OP_ADD        = 5'b00011,
    parameter logic [OPW-1:0] OP_SUB        = 5'b00100,
    parameter logic [OPW-1:0] OP_BR         = 5'b10010,
    parameter logic [OPW-1:0] OP_JAL        = 5'b10011,
    parameter logic [OPW-1:0] OP_JR         = 5'b10100,
    parameter logic [OPW-1:0] OP_HALT       = 5'b11011
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    input  logic            con_ff,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Cout,
    output logic            BAout,
    output logic            Rout,
    output logic            MARIn,
    output logic            PCIn,
    output logic            MDRIn,
    output logic            IRIn,
    output logic            YIn,
    output logic            ZIn,
    output logic            RIn,
    output logic            CONIn,
    output logic            IncPC,
    output logic            read,
    output logic            write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            add,
    output logic            subtract,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      step
);

    // State encoding equals the externally visible step code.
    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_T7   = 4'h7,
        S_HALT = 4'hE,
        S_IDLE = 4'hF
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] opcode;
    logic           mem_go;
    logic           unused_ir_bits;

    assign opcode = ir[IR_W-1 -: OPW];
    // Operand fields are decoded by the datapath, not by the sequencer.
    assign unused_ir_bits = ^ir[IR_W-OPW-1:0];
    // Without the handshake every memory step completes in a single cycle.
    assign mem_go = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign step   = state_q;

    // State register; clr forces IDLE immediately, even mid-wait.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode from the registered step and the opcode.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        Cout     = 1'b0;
        BAout    = 1'b0;
        Rout     = 1'b0;
        MARIn    = 1'b0;
        PCIn     = 1'b0;
        MDRIn    = 1'b0;
        IRIn     = 1'b0;
        YIn      = 1'b0;
        ZIn      = 1'b0;
        RIn      = 1'b0;
        CONIn    = 1'b0;
        IncPC    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        add      = 1'b0;
        subtract = 1'b0;
        run      = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1;
                if (mem_go) state_d = S_T2;
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRIn = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                run = 1'b1;
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        Grb = 1'b1; Rout = 1'b1; YIn = 1'b1; state_d = S_T4;
                    end
                    OP_LD, OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; YIn = 1'b1; state_d = S_T4;
                    end
                    OP_JR: begin
                        Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1; state_d = S_T0;
                    end
                    OP_JAL: begin
                        PCout = 1'b1; Grb = 1'b1; RIn = 1'b1; state_d = S_T4;
                    end
                    OP_BR: begin
                        Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; state_d = S_T4;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        illegal = 1'b1; state_d = S_T0;
                    end
                endcase
            end
            S_T4: begin
                run = 1'b1;
                state_d = S_T0;
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        Grc = 1'b1; Rout = 1'b1; ZIn = 1'b1;
                        add = (opcode == OP_ADD); subtract = (opcode == OP_SUB);
                        state_d = S_T5;
                    end
                    OP_LD, OP_ST: begin
                        Cout = 1'b1; add = 1'b1; ZIn = 1'b1; state_d = S_T5;
                    end
                    OP_JAL: begin
                        Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1;
                    end
                    OP_BR: begin
                        PCout = 1'b1; YIn = 1'b1; state_d = S_T5;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                run = 1'b1;
                state_d = S_T0;
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        Zlowout = 1'b1; Gra = 1'b1; RIn = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        Zlowout = 1'b1; MARIn = 1'b1; state_d = S_T6;
                    end
                    OP_BR: begin
                        Cout = 1'b1; add = 1'b1; ZIn = 1'b1; state_d = S_T6;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                run = 1'b1;
                state_d = S_T0;
                case (opcode)
                    OP_LD: begin
                        read = 1'b1; MDRIn = 1'b1;
                        state_d = mem_go ? S_T7 : S_T6;
                    end
                    OP_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1; state_d = S_T7;
                    end
                    OP_BR: begin
                        Zlowout = 1'b1; PCIn = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                run = 1'b1;
                state_d = S_T0;
                case (opcode)
                    OP_LD: begin
                        MDRout = 1'b1; Gra = 1'b1; RIn = 1'b1;
                    end
                    OP_ST: begin
                        write = 1'b1;
                        state_d = mem_go ? S_T0 : S_T7;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
